// File: rtl/divclk_monitor_pkg.sv
// Shared TTC clock-divider definitions.
//  state_t       : monitor FSM encoding (value 3 is illegal and recovers to IDLE)
//  DIV2_PERIOD   : expected period of the /2 divided clock, in clk cycles
//  DIV16_PERIOD  : expected period of the /16 divided clock, in clk cycles
//  abs_diff()    : magnitude of the difference of two unsigned values
package divclk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int unsigned DIV2_PERIOD  = 2;
  localparam int unsigned DIV16_PERIOD = 16;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/divclk_monitor_edge_sync.sv
// Three-flop synchroniser for an asynchronous level, with registered
// one-cycle edge strobes. Reusable for any async TTC input.
//  clk      in  system clock
//  init     in  synchronous reset, active-high
//  din      in  asynchronous level
//  rise_stb out 1-cycle pulse per synchronised rising edge
//  fall_stb out 1-cycle pulse per synchronised falling edge
//  level    out synchronised level, time-aligned with the strobes
module edge_sync (
  input  logic clk,
  input  logic init,
  input  logic din,
  output logic rise_stb,
  output logic fall_stb,
  output logic level
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (init) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      sync3    <= sync2;
      rise_stb <= sync2 & ~sync3;
      fall_stb <= ~sync2 & sync3;
    end
  end

  // sync3 changes on the same edge the strobes assert, so a counter gated
  // by it counts exactly the high cycles between a rise and its fall.
  assign level = sync3;

endmodule

// File: rtl/divclk_monitor.sv
// Receive-side monitor for a TTC divided clock. Synchronises div_in,
// produces edge strobes used downstream as clock enables, measures the
// rise-to-rise period and the high time, and tracks lock against an
// expected period.
//  clk        in  system clock
//  init       in  synchronous reset, active-high
//  div_in     in  divided clock / square wave, async to clk
//  rise_stb   out 1-cycle pulse per synchronised rising edge
//  fall_stb   out 1-cycle pulse per synchronised falling edge
//  period     out last rise-to-rise interval in clk cycles
//  period_vld out period holds a real measurement
//  high_time  out last rise-to-fall interval in clk cycles
//  locked     out monitor is in LOCK
//  lost_stb   out 1-cycle pulse when lock is lost
module divclk_monitor
  import divclk_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = DIV16_PERIOD,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             init,
  input  logic             div_in,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             lost_stb
);

  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);

  logic rise, fall, level;

  edge_sync u_sync (
    .clk      (clk),
    .init     (init),
    .din      (div_in),
    .rise_stb (rise),
    .fall_stb (fall),
    .level    (level)
  );

  assign rise_stb = rise;
  assign fall_stb = fall;

  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [3:0]       good_cnt, good_cnt_nx;
  logic             seen_rise;   // a rise has occurred since reset / IDLE
  logic             armed;       // a rise has occurred since reset
  state_t           state, state_nx;
  logic             lost_nx, to_idle, good, timeout;

  // A period is only meaningful once a previous rise started the count.
  assign good    = seen_rise &&
                   (abs_diff(32'(per_cnt), EXP_PERIOD) <= TOL);
  assign timeout = (per_cnt == TMO_C);

  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    lost_nx     = 1'b0;
    to_idle     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nx    = ST_ACQ;
          good_cnt_nx = '0;
        end
      end
      ST_ACQ: begin
        if (rise) begin
          if (good) begin
            if (good_cnt + 4'd1 == LOCK_C) begin
              state_nx    = ST_LOCK;
              good_cnt_nx = '0;
            end else begin
              good_cnt_nx = good_cnt + 4'd1;
            end
          end else begin
            good_cnt_nx = '0;
          end
        end else if (timeout) begin
          state_nx = ST_IDLE;
          to_idle  = 1'b1;
        end
      end
      ST_LOCK: begin
        if (rise) begin
          if (!good) begin
            state_nx    = ST_ACQ;
            good_cnt_nx = '0;
            lost_nx     = 1'b1;
          end
        end else if (timeout) begin
          state_nx = ST_IDLE;
          to_idle  = 1'b1;
          lost_nx  = 1'b1;
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        good_cnt_nx = '0;
        to_idle     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state      <= ST_IDLE;
      good_cnt   <= '0;
      locked     <= 1'b0;
      lost_stb   <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      high_time  <= '0;
      seen_rise  <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
      locked   <= (state_nx == ST_LOCK);
      lost_stb <= lost_nx;

      if (rise)
        per_cnt <= CNT_W'(1);
      else if (per_cnt != '1)
        per_cnt <= per_cnt + CNT_W'(1);

      if (rise)
        hi_cnt <= CNT_W'(1);
      else if (level && hi_cnt != '1)
        hi_cnt <= hi_cnt + CNT_W'(1);

      if (rise) begin
        period    <= per_cnt;
        seen_rise <= 1'b1;
        armed     <= 1'b1;
        if (seen_rise)
          period_vld <= 1'b1;
      end else if (to_idle) begin
        seen_rise  <= 1'b0;
        period_vld <= 1'b0;
      end

      if (fall && armed)
        high_time <= hi_cnt;
    end
  end

endmodule

// File: tb/tb_divclk_monitor.sv
module tb_divclk_monitor;
  import divclk_monitor_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic init = 1'b1, div16 = 1'b0, div2 = 1'b0;

  logic       r16, f16, v16, l16, ls16;
  logic [7:0] p16, h16;
  logic       r2, f2, v2, l2, ls2;
  logic [7:0] p2, h2;

  divclk_monitor #(.CNT_W(8), .EXP_PERIOD(DIV16_PERIOD), .TOL(1),
                   .LOCK_CNT(4), .TIMEOUT(64)) u16 (
    .clk(clk), .init(init), .div_in(div16), .rise_stb(r16), .fall_stb(f16),
    .period(p16), .period_vld(v16), .high_time(h16), .locked(l16), .lost_stb(ls16));

  divclk_monitor #(.CNT_W(8), .EXP_PERIOD(DIV2_PERIOD), .TOL(0),
                   .LOCK_CNT(4), .TIMEOUT(64)) u2 (
    .clk(clk), .init(init), .div_in(div2), .rise_stb(r2), .fall_stb(f2),
    .period(p2), .period_vld(v2), .high_time(h2), .locked(l2), .lost_stb(ls2));

  // Reference model: edges are found from a history of sampled input bits,
  // intervals are differences of edge-event cycle numbers.
  typedef struct {
    int   k;
    logic [3:0] h;
    logic rv, fv;
    int   st, gc;
    bit   seen, vld, has_rise, lost;
    int   origin, oval, jr, period, high;
  } mdl_t;

  typedef struct {
    logic init, div, rise, fall, vld, lck;
  } vec_t;

  mdl_t m16, m2;
  int   checks = 0, failures = 0;
  int   lost16 = 0, rise2 = 0, mode2 = 0;
  logic tog = 1'b0;
  vec_t tbl[11];

  function automatic void mstep(inout mdl_t m, input logic i, input logic d,
                                input int exp_p, input int tol, input int lockc, input int tmo);
    int pre, diff;
    logic rise, fall;
    bit good;
    m.k++;
    if (i) begin
      m.h = '0; m.rv = 0; m.fv = 0; m.st = 0; m.gc = 0; m.seen = 0; m.vld = 0;
      m.has_rise = 0; m.lost = 0; m.origin = m.k; m.oval = 0; m.jr = 0;
      m.period = 0; m.high = 0;
      return;
    end
    rise = m.rv; fall = m.fv; m.lost = 0;
    pre = m.oval + (m.k - 1 - m.origin);
    if (pre > 255) pre = 255;
    if (rise) begin
      diff = pre - exp_p;
      if (diff < 0) diff = -diff;
      good = m.seen && (diff <= tol);
      m.period = pre;
      if (m.seen) m.vld = 1;
      m.seen = 1; m.origin = m.k; m.oval = 1; m.jr = m.k; m.has_rise = 1;
      case (m.st)
        0: begin m.st = 1; m.gc = 0; end
        1: if (good) begin
             m.gc++;
             if (m.gc == lockc) begin m.st = 2; m.gc = 0; end
           end else m.gc = 0;
        default: if (!good) begin m.st = 1; m.gc = 0; m.lost = 1; end
      endcase
    end else if (m.st != 0 && pre == tmo) begin
      m.lost = (m.st == 2); m.st = 0; m.vld = 0; m.seen = 0;
    end
    if (fall && m.has_rise) begin
      m.high = m.k - m.jr;
      if (m.high > 255) m.high = 255;
    end
    m.h  = {m.h[2:0], d};
    m.rv = m.h[2] & ~m.h[3];
    m.fv = ~m.h[2] & m.h[3];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic r, input logic f,
                     input logic [7:0] p, input logic v, input logic [7:0] h,
                     input logic l, input logic ls);
    chk({tag, ".rise_stb"}, 32'(r), 32'(m.rv));
    chk({tag, ".fall_stb"}, 32'(f), 32'(m.fv));
    chk({tag, ".period"}, 32'(p), 32'(m.period));
    chk({tag, ".period_vld"}, 32'(v), 32'(m.vld));
    chk({tag, ".high_time"}, 32'(h), 32'(m.high));
    chk({tag, ".locked"}, 32'(l), 32'(m.st == 2));
    chk({tag, ".lost_stb"}, 32'(ls), 32'(m.lost));
    chk({tag, ".strobe_excl"}, 32'(r & f), 32'(0));
  endtask

  task automatic step(input logic i, input logic a);
    init  = i;
    div16 = a;
    div2  = (mode2 == 0) ? tog : 1'($urandom_range(0, 1));
    tog   = ~tog;
    @(posedge clk);
    #1;
    mstep(m16, i, a, 16, 1, 4, 64);
    mstep(m2, i, div2, 2, 0, 4, 64);
    cmp("u16", m16, r16, f16, p16, v16, h16, l16, ls16);
    cmp("u2", m2, r2, f2, p2, v2, h2, l2, ls2);
    if (ls16) lost16++;
    if (r2) rise2++;
  endtask

  task automatic per(input int len, input int hi);
    for (int c = 0; c < len; c++) step(1'b0, 1'(c < hi));
  endtask

  initial begin
    // {init, div_in, rise_stb, fall_stb, period_vld, locked} for u16
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].init, tbl[i].div);
      chk("tbl.rise_stb", 32'(r16), 32'(tbl[i].rise));
      chk("tbl.fall_stb", 32'(f16), 32'(tbl[i].fall));
      chk("tbl.period_vld", 32'(v16), 32'(tbl[i].vld));
      chk("tbl.locked", 32'(l16), 32'(tbl[i].lck));
      if (tbl[i].init) begin
        chk("tbl.reset_period", 32'(p16), 32'(0));
        chk("tbl.reset_high", 32'(h16), 32'(0));
        chk("tbl.reset_lost", 32'(ls16), 32'(0));
      end
    end

    // /16 lock
    lost16 = 0;
    for (int n = 0; n < 7; n++) per(16, 8);
    chk("div16.locked", 32'(l16), 32'(1));
    chk("div16.period", 32'(p16), 32'(16));
    chk("div16.high_time", 32'(h16), 32'(8));
    chk("div16.no_lost", 32'(lost16), 32'(0));

    // one long period breaks lock, four good periods restore it
    lost16 = 0;
    per(20, 10);
    per(16, 8);
    chk("long.lost_cnt", 32'(lost16), 32'(1));
    chk("long.unlocked", 32'(l16), 32'(0));
    for (int n = 0; n < 5; n++) per(16, 8);
    chk("long.relocked", 32'(l16), 32'(1));
    chk("long.lost_once", 32'(lost16), 32'(1));

    // /2 instance, driven by a continuous toggle
    rise2 = 0;
    for (int n = 0; n < 20; n++) step(1'b0, 1'b0);
    chk("div2.rise_cnt", 32'(rise2), 32'(10));
    chk("div2.period", 32'(p2), 32'(2));
    chk("div2.high_time", 32'(h2), 32'(1));
    chk("div2.locked", 32'(l2), 32'(1));

    // stuck low -> timeout to IDLE, then relock
    per(16, 8);
    for (int n = 0; n < 5; n++) per(16, 8);
    lost16 = 0;
    for (int n = 0; n < 100; n++) step(1'b0, 1'b0);
    chk("stuck.lost_cnt", 32'(lost16), 32'(1));
    chk("stuck.unlocked", 32'(l16), 32'(0));
    chk("stuck.vld", 32'(v16), 32'(0));
    for (int n = 0; n < 6; n++) per(16, 8);
    chk("stuck.relocked", 32'(l16), 32'(1));

    // 15/17 jitter within tolerance holds lock; 18 loses it
    lost16 = 0;
    for (int n = 0; n < 4; n++) begin per(15, 8); per(17, 8); end
    chk("jitter.locked", 32'(l16), 32'(1));
    chk("jitter.no_lost", 32'(lost16), 32'(0));
    per(18, 9);
    per(16, 8);
    chk("p18.lost_cnt", 32'(lost16), 32'(1));
    for (int n = 0; n < 5; n++) per(16, 8);
    chk("p18.relocked", 32'(l16), 32'(1));
    step(1'b1, 1'b1);
    chk("init.unlocked", 32'(l16), 32'(0));
    step(1'b0, 1'b0);

    // randomized traffic on both instances against the model
    for (int n = 0; n < 160; n++) begin
      int sel, len;
      mode2 = (n % 4 == 3) ? 1 : 0;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        len = $urandom_range(40, 90);
        begin
          logic lv;
          lv = 1'($urandom_range(0, 1));
          for (int c = 0; c < len; c++) step(1'b0, lv);
        end
      end else if (sel == 1) begin
        for (int c = 0; c < 10; c++) step(1'b0, 1'($urandom_range(0, 1)));
      end else if (sel == 2) begin
        step(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        len = $urandom_range(13, 19);
        per(len, $urandom_range(1, len - 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
